k2_control_unit: RTL and testbench

Multi-cycle fetch/execute sequencer for the K2 8-bit datapath (RA, RB, RO, ALU). It owns the program counter, fetches instructions from an instruction memory over a request/valid handshake, and decodes them into single-cycle register write enables and ALU controls. It holds the carry flag used by conditional jumps. It sits between instruction ROM and the existing execution datapath, replacing hard-wired program sequencing.

---
 rtl/k2_control_unit.sv | 112 +++++++++++
 tb/tb_k2_control_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k2_control_unit.sv
// K2 fetch/execute sequencer: owns PC, IR and carry flag, fetches over a
// req/valid handshake and decodes one instruction per EXEC cycle.
module k2_control_unit #(
  parameter int ADDR_W   = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_valid,
  input  logic              alu_carry,
  output logic [1:0]        alu_op,
  output logic              imm_sel,
  output logic [2:0]        imm,
  output logic              ra_we,
  output logic              rb_we,
  output logic              ro_we,
  output logic [ADDR_W-1:0] pc,
  output logic              carry,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  localparam logic [1:0] OPC_REG = 2'b00;
  localparam logic [1:0] OPC_J   = 2'b10;
  localparam logic [1:0] OPC_JC  = 2'b11;

  localparam logic [7:0] IR_NOP = 8'h40;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [7:0]        ir;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nx;
  logic              carry_q;

  logic [1:0]        opc;
  logic [1:0]        dst;
  logic              is_reg;
  logic              is_alu;
  logic              exec;
  logic              fetch;
  logic [ADDR_W-1:0] tgt;

  assign opc    = ir[7:6];
  assign dst    = ir[5:4];
  assign is_reg = (opc == OPC_REG);
  assign is_alu = is_reg & ~ir[3];
  assign tgt    = ir[ADDR_W-1:0];
  assign exec   = (state == S_EXEC);
  assign fetch  = (state == S_FETCH);

  assign imem_req  = fetch;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign carry     = carry_q;
  assign busy      = (state != S_IDLE);

  // Datapath controls follow IR in every state; only the enables are gated.
  assign alu_op  = ir[2:1];
  assign imm_sel = is_reg & ir[3];
  assign imm     = ir[2:0];

  assign ra_we = exec & is_reg & (dst == 2'b00);
  assign rb_we = exec & is_reg & (dst == 2'b01);
  assign ro_we = exec & is_reg & (dst == 2'b10);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (run | step) state_nx = S_FETCH;
      S_FETCH: if (imem_valid) state_nx = S_EXEC;
      S_EXEC:  state_nx = run ? S_FETCH : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // JC tests the flag as it stands; jumps never touch carry.
  always_comb begin
    pc_nx = pc_q + ADDR_W'(1);
    unique case (1'b1)
      (opc == OPC_J):            pc_nx = tgt;
      (opc == OPC_JC) & carry_q: pc_nx = tgt;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      ir      <= IR_NOP;
      carry_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (fetch & imem_valid)
        ir <= imem_rdata;
      if (exec)
        pc_q <= pc_nx;
      if (exec & is_alu)
        carry_q <= alu_carry;
    end
  end

endmodule

// File: tb/tb_k2_control_unit.sv
// Scoreboard bench for k2_control_unit: expected EXEC cycles are queued by
// the stimulus and checked by an independent monitor.
module tb_k2_control_unit;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       step;
  logic [3:0] imem_addr;
  logic       imem_req;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic       alu_carry;
  logic [1:0] alu_op;
  logic       imm_sel;
  logic [2:0] imm;
  logic       ra_we;
  logic       rb_we;
  logic       ro_we;
  logic [3:0] pc;
  logic       carry;
  logic       busy;

  k2_control_unit #(.ADDR_W(4), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .alu_carry(alu_carry), .alu_op(alu_op), .imm_sel(imm_sel),
    .imm(imm), .ra_we(ra_we), .rb_we(rb_we), .ro_we(ro_we),
    .pc(pc), .carry(carry), .busy(busy)
  );

  typedef struct {
    int         cyc;
    logic [3:0] pc;
    logic       c;
    logic [2:0] we;
    logic [1:0] op;
    logic       isel;
    logic [2:0] imm;
  } rec_t;

  rec_t q[$];
  int   nchk;
  int   nerr;
  int   cyc;
  int   lat;
  int   wcnt;
  logic stray;
  logic [7:0] rom [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: valid after lat wait cycles, stray valid only when stray=1
  always @(posedge clk)
    wcnt <= (imem_req && !imem_valid) ? wcnt + 1 : 0;

  assign imem_valid = stray | (imem_req && (wcnt >= lat));
  assign imem_rdata = rom[imem_addr];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(int c_, logic [3:0] pc_, logic cf_, logic [2:0] we_,
                      logic [1:0] op_, logic is_, logic [2:0] im_);
    rec_t r;
    r.cyc = c_; r.pc = pc_; r.c = cf_; r.we = we_;
    r.op = op_; r.isel = is_; r.imm = im_;
    q.push_back(r);
  endtask

  // EXEC monitor
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy && !imem_req) begin
          nchk++;
          if (q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_exec: pc=%0d cyc=%0d", pc, cyc);
          end else begin
            e = q.pop_front();
            if (cyc != e.cyc || pc !== e.pc || carry !== e.c ||
                {ra_we, rb_we, ro_we} !== e.we || alu_op !== e.op ||
                imm_sel !== e.isel || imm !== e.imm) begin
              nerr++;
              $display("FAIL exec: got cyc=%0d pc=%0d c=%b we=%b op=%b isel=%b imm=%b expected cyc=%0d pc=%0d c=%b we=%b op=%b isel=%b imm=%b",
                       cyc, pc, carry, {ra_we, rb_we, ro_we}, alu_op, imm_sel, imm,
                       e.cyc, e.pc, e.c, e.we, e.op, e.isel, e.imm);
            end
          end
        end else if (ra_we || rb_we || ro_we) begin
          nchk++;
          nerr++;
          $display("FAIL stray_we: got we=%b expected 000 cyc=%0d",
                   {ra_we, rb_we, ro_we}, cyc);
        end
      end
    end
  end

  // Fetch monitor: request length and address against the scoreboard
  initial begin
    int reqlen;
    reqlen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        reqlen = 0;
      end else if (imem_req) begin
        reqlen++;
        if (q.size() > 0)
          chk("fetch_addr", 32'(imem_addr), 32'(q[0].pc));
      end else if (reqlen > 0) begin
        chk("req_len", 32'(reqlen), 32'(lat + 1));
        reqlen = 0;
      end
    end
  end

  task automatic sync(output int t);
    @(negedge clk);
    t = cyc;
  endtask

  task automatic run_for(int n);
    run = 1'b1;
    repeat ((lat + 2) * n) @(negedge clk);
    run = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic step_pulse();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (lat + 8) @(negedge clk);
  endtask

  task automatic chk_reset_outs();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_we", 32'({ra_we, rb_we, ro_we}), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_aluop", 32'(alu_op), 0);
    chk("rst_immsel", 32'(imm_sel), 0);
    chk("rst_imm", 32'(imm), 0);
  endtask

  initial begin
    int t;
    nchk = 0; nerr = 0;
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    stray = 1'b0; lat = 0; alu_carry = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h40;
    rom[0] = 8'h09; rom[1] = 8'h19; rom[2] = 8'h20; rom[3] = 8'h80;

    repeat (3) @(negedge clk);
    chk_reset_outs();
    chk("rst_addr", 32'(imem_addr), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // zero-wait program: RA<-1, RB<-1, RO<-RA+RB, J 0
    sync(t);
    push(t + 2, 4'd0, 1'b0, 3'b100, 2'b00, 1'b1, 3'b001);
    push(t + 4, 4'd1, 1'b0, 3'b010, 2'b00, 1'b1, 3'b001);
    push(t + 6, 4'd2, 1'b0, 3'b001, 2'b00, 1'b0, 3'b000);
    push(t + 8, 4'd3, 1'b0, 3'b000, 2'b00, 1'b0, 3'b000);
    run_for(4);
    chk("zw_pc", 32'(pc), 0);
    chk("zw_busy", 32'(busy), 0);

    // same program with 3 wait states per fetch
    lat = 3;
    sync(t);
    push(t + 5,  4'd0, 1'b0, 3'b100, 2'b00, 1'b1, 3'b001);
    push(t + 10, 4'd1, 1'b0, 3'b010, 2'b00, 1'b1, 3'b001);
    push(t + 15, 4'd2, 1'b0, 3'b001, 2'b00, 1'b0, 3'b000);
    push(t + 20, 4'd3, 1'b0, 3'b000, 2'b00, 1'b0, 3'b000);
    run_for(4);
    chk("ws_pc", 32'(pc), 0);

    // JC taken: ADD (no write) with carry out, then JC 5
    lat = 0;
    rom[0] = 8'h30; rom[1] = 8'hC5; rom[5] = 8'h40; rom[6] = 8'h80;
    alu_carry = 1'b1;
    sync(t);
    push(t + 2, 4'd0, 1'b0, 3'b000, 2'b00, 1'b0, 3'b000);
    push(t + 4, 4'd1, 1'b1, 3'b000, 2'b10, 1'b0, 3'b101);
    push(t + 6, 4'd5, 1'b1, 3'b000, 2'b00, 1'b0, 3'b000);
    run_for(3);
    chk("jc1_carry", 32'(carry), 1);
    chk("jc1_pc", 32'(pc), 6);

    // JC not taken
    alu_carry = 1'b0;
    sync(t);
    push(t + 2, 4'd6, 1'b1, 3'b000, 2'b00, 1'b0, 3'b000);
    push(t + 4, 4'd0, 1'b1, 3'b000, 2'b00, 1'b0, 3'b000);
    push(t + 6, 4'd1, 1'b0, 3'b000, 2'b10, 1'b0, 3'b101);
    push(t + 8, 4'd2, 1'b0, 3'b001, 2'b00, 1'b0, 3'b000);
    run_for(4);
    chk("jc0_carry", 32'(carry), 0);
    chk("jc0_pc", 32'(pc), 3);

    // wrap: J 15, NOP at 15, RB<-1 at 0
    rom[3] = 8'h8F; rom[15] = 8'h40; rom[0] = 8'h19;
    sync(t);
    push(t + 2, 4'd3,  1'b0, 3'b000, 2'b11, 1'b0, 3'b111);
    push(t + 4, 4'd15, 1'b0, 3'b000, 2'b00, 1'b0, 3'b000);
    push(t + 6, 4'd0,  1'b0, 3'b010, 2'b00, 1'b1, 3'b001);
    run_for(3);
    chk("wrap_pc", 32'(pc), 1);

    // run dropped during the first fetch cycle
    lat = 3;
    sync(t);
    push(t + 5, 4'd1, 1'b0, 3'b000, 2'b10, 1'b0, 3'b101);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (10) @(negedge clk);
    chk("drop_busy", 32'(busy), 0);
    chk("drop_pc", 32'(pc), 2);

    // step pulses while busy are ignored
    sync(t);
    push(t + 5, 4'd2, 1'b0, 3'b001, 2'b00, 1'b0, 3'b000);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (12) @(negedge clk);
    chk("sbusy_pc", 32'(pc), 3);
    chk("sbusy_busy", 32'(busy), 0);

    // single step from IDLE, zero wait
    lat = 0;
    sync(t);
    push(t + 2, 4'd3, 1'b0, 3'b000, 2'b11, 1'b0, 3'b111);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_busy", 32'(busy), 1);
    chk("step_req", 32'(imem_req), 1);
    repeat (6) @(negedge clk);
    chk("step_pc", 32'(pc), 15);
    chk("step_idle", 32'(busy), 0);

    // set carry and a non-NOP IR before reset
    alu_carry = 1'b1;
    rom[15] = 8'h30; rom[0] = 8'h3F;
    sync(t);
    push(t + 2, 4'd15, 1'b0, 3'b000, 2'b00, 1'b0, 3'b000);
    step_pulse();
    sync(t);
    push(t + 2, 4'd0, 1'b1, 3'b000, 2'b11, 1'b1, 3'b111);
    step_pulse();
    chk("pre_carry", 32'(carry), 1);
    chk("pre_pc", 32'(pc), 1);
    chk("pre_aluop", 32'(alu_op), 3);

    // reset in the middle of a long fetch with valid forced high
    lat = 10;
    @(negedge clk);
    run = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_busy", 32'(busy), 0);
    chk("post_aluop", 32'(alu_op), 0);
    chk("post_imm", 32'(imm), 0);
    chk("post_pc", 32'(pc), 0);
    stray = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
